// File: rtl/smc_wr_pkg.sv
// Shared types and codes for the SMC bank AXI write slave.
// FSM state encoding, B response codes and AXI burst types.
package smc_wr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_RESP = 2'b10
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

endpackage

// File: rtl/smc_wr_addr_gen.sv
// Word address and beat counter for one write burst: loads on AW, steps per beat.
// INCR wraps modulo 2^MEM_ADDR_WIDTH, FIXED holds; last is high on the final beat.
module smc_wr_addr_gen
  import smc_wr_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      load,
  input  logic                      step,
  input  logic [MEM_ADDR_WIDTH-1:0] load_addr,
  input  logic [3:0]                load_len,
  input  logic [1:0]                load_burst,
  output logic [MEM_ADDR_WIDTH-1:0] addr,
  output logic                      last
);

  logic [MEM_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [3:0]                len_q, len_d;
  logic                      incr_q, incr_d;

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    len_d  = len_q;
    incr_d = incr_q;
    if (load) begin
      addr_d = load_addr;
      cnt_d  = 4'd0;
      len_d  = load_len;
      incr_d = (load_burst == BURST_INCR);
    end else if (step) begin
      cnt_d = cnt_q + 4'd1;
      if (incr_q) begin
        addr_d = addr_q + MEM_ADDR_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      cnt_q  <= '0;
      len_q  <= '0;
      incr_q <= 1'b0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
      len_q  <= len_d;
      incr_q <= incr_d;
    end
  end

  assign addr = addr_q;
  assign last = (cnt_q == len_q);

endmodule

// File: rtl/smc_wr_slave.sv
// AXI write slave for one SMC bank: one burst at a time, each beat becomes a registered SRAM word write.
// SMC_WR_PERF_CNT_EN adds wrapping burst and error counters on the B handshake.
module smc_wr_slave
  import smc_wr_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    DATA_WIDTH     = 128,
  parameter int                    BYTE_STRB      = DATA_WIDTH / 8,
  parameter int                    MEM_ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 32'h1000_0000
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [3:0]                awid,
  input  logic                      awvalid,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic [3:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic                      awlock,
  input  logic [3:0]                awcache,
  input  logic [2:0]                awprot,
  output logic                      awready,
  input  logic                      wvalid,
  input  logic                      wlast,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [BYTE_STRB-1:0]      wstrb,
  output logic                      wready,
  output logic [3:0]                bid,
  output logic                      bvalid,
  output logic [1:0]                bresp,
  input  logic                      bready,
  output logic                      o_mem_we,
  output logic [MEM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0]     o_mem_wdata,
  output logic [BYTE_STRB-1:0]      o_mem_wstrb,
`ifdef SMC_WR_PERF_CNT_EN
  output logic [15:0]               o_burst_cnt,
  output logic [15:0]               o_err_cnt,
`endif
  output logic [1:0]                o_state
);

  localparam int LSB = $clog2(BYTE_STRB);
  localparam int WIN = LSB + MEM_ADDR_WIDTH;

  state_e                    state_q, state_d;
  logic                      awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
  logic [3:0]                id_q, id_d, bid_q, bid_d;
  logic [1:0]                err_q, err_d, bresp_q, bresp_d;
  logic                      wr_ok_q, wr_ok_d, mem_we_q, mem_we_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]     mem_wdata_q, mem_wdata_d;
  logic [BYTE_STRB-1:0]      mem_wstrb_q, mem_wstrb_d;
  logic                      aw_hs, w_hs, b_hs, ag_last;
  logic [MEM_ADDR_WIDTH-1:0] ag_addr;
  logic [1:0]                aw_err;
  logic                      unused_ok;

  assign aw_hs     = awready_q & awvalid;
  assign w_hs      = wready_q & wvalid;
  assign b_hs      = bvalid_q & bready;
  assign unused_ok = ^{awlock, awcache, awprot, awaddr[LSB-1:0]};

  // Decode error outranks protocol error; awburst[1] set means neither FIXED nor INCR.
  always_comb begin
    aw_err = RESP_OKAY;
    if (awaddr[ADDR_WIDTH-1:WIN] != BASE_ADDR[ADDR_WIDTH-1:WIN]) begin
      aw_err = RESP_DECERR;
    end else if (awsize != 3'(LSB) || awburst[1]) begin
      aw_err = RESP_SLVERR;
    end
  end

  smc_wr_addr_gen #(.MEM_ADDR_WIDTH(MEM_ADDR_WIDTH)) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (aw_hs),
    .step       (w_hs),
    .load_addr  (awaddr[WIN-1:LSB]),
    .load_len   (awlen),
    .load_burst (awburst),
    .addr       (ag_addr),
    .last       (ag_last)
  );

  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    err_d       = err_q;
    wr_ok_d     = wr_ok_q;
    bid_d       = bid_q;
    bresp_d     = bresp_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    case (state_q)
      ST_IDLE: begin
        if (aw_hs) begin
          id_d    = awid;
          err_d   = aw_err;
          wr_ok_d = (aw_err == RESP_OKAY);
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_hs) begin
          mem_we_d = wr_ok_q;
          if (wr_ok_q) begin
            mem_addr_d  = ag_addr;
            mem_wdata_d = wdata;
            mem_wstrb_d = wstrb;
          end
          // A misplaced wlast flags the response but never shortens the burst.
          if (err_q == RESP_OKAY && wlast != ag_last) begin
            err_d = RESP_SLVERR;
          end
          if (ag_last) begin
            bid_d   = id_q;
            bresp_d = err_d;
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (b_hs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    awready_d = (state_d == ST_IDLE);
    wready_d  = (state_d == ST_DATA);
    bvalid_d  = (state_d == ST_RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      id_q        <= '0;
      err_q       <= RESP_OKAY;
      wr_ok_q     <= 1'b0;
      bid_q       <= '0;
      bresp_q     <= RESP_OKAY;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
    end else begin
      state_q     <= state_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      id_q        <= id_d;
      err_q       <= err_d;
      wr_ok_q     <= wr_ok_d;
      bid_q       <= bid_d;
      bresp_q     <= bresp_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
    end
  end

`ifdef SMC_WR_PERF_CNT_EN
  logic [15:0] burst_cnt_q, burst_cnt_d, err_cnt_q, err_cnt_d;

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (b_hs) begin
      burst_cnt_d = burst_cnt_q + 16'd1;
      if (bresp_q != RESP_OKAY) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_burst_cnt = burst_cnt_q;
  assign o_err_cnt   = err_cnt_q;
`endif

  assign awready     = awready_q;
  assign wready      = wready_q;
  assign bvalid      = bvalid_q;
  assign bid         = bid_q;
  assign bresp       = bresp_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;
  assign o_mem_wstrb = mem_wstrb_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_smc_wr_slave.sv
// Directed bench for smc_wr_slave: inputs driven and outputs sampled on the falling edge.
// SRAM writes are collected by a monitor; each test task checks its own results.
module tb_smc_wr_slave;

  localparam int DW = 128;
  localparam int SW = 16;
  localparam int MW = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    awid = '0;
  logic          awvalid = 1'b0;
  logic [31:0]   awaddr = '0;
  logic [3:0]    awlen = '0;
  logic [2:0]    awsize = '0;
  logic [1:0]    awburst = '0;
  logic          awlock = 1'b0;
  logic [3:0]    awcache = '0;
  logic [2:0]    awprot = '0;
  logic          awready;
  logic          wvalid = 1'b0;
  logic          wlast = 1'b0;
  logic [DW-1:0] wdata = '0;
  logic [SW-1:0] wstrb = '0;
  logic          wready;
  logic [3:0]    bid;
  logic          bvalid;
  logic [1:0]    bresp;
  logic          bready = 1'b0;
  logic          o_mem_we;
  logic [MW-1:0] o_mem_addr;
  logic [DW-1:0] o_mem_wdata;
  logic [SW-1:0] o_mem_wstrb;
  logic [1:0]    o_state;
`ifdef SMC_WR_PERF_CNT_EN
  logic [15:0]   o_burst_cnt;
  logic [15:0]   o_err_cnt;
`endif

  int total = 0;
  int bad = 0;

  logic [MW-1:0] q_addr[$];
  logic [DW-1:0] q_data[$];
  logic [SW-1:0] q_strb[$];

  always #5 clk = ~clk;

  smc_wr_slave dut (
    .clk(clk), .rst_n(rst_n),
    .awid(awid), .awvalid(awvalid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awlock(awlock), .awcache(awcache), .awprot(awprot), .awready(awready),
    .wvalid(wvalid), .wlast(wlast), .wdata(wdata), .wstrb(wstrb), .wready(wready),
    .bid(bid), .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata), .o_mem_wstrb(o_mem_wstrb),
`ifdef SMC_WR_PERF_CNT_EN
    .o_burst_cnt(o_burst_cnt), .o_err_cnt(o_err_cnt),
`endif
    .o_state(o_state)
  );

  always @(negedge clk) begin
    if (o_mem_we === 1'b1) begin
      q_addr.push_back(o_mem_addr);
      q_data.push_back(o_mem_wdata);
      q_strb.push_back(o_mem_wstrb);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] beat_data(input logic [31:0] seed, input int i);
    logic [31:0] w;
    w = seed + 32'(i);
    return {4{w}};
  endfunction

  task automatic clear_q();
    q_addr.delete();
    q_data.delete();
    q_strb.delete();
  endtask

  // Returns at the falling edge right after the AW handshake edge.
  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int n;
    n = 0;
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    while (awready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (awready !== 1'b1) begin
      bad++;
      $display("FAIL aw_timeout: awready=%b required 1", awready);
    end
    @(negedge clk);
    awvalid = 1'b0;
  endtask

  // Called at a falling edge; returns at the falling edge after the last beat handshake.
  task automatic send_beats(input int nb, input logic [63:0] strbs, input int last_idx,
                            input logic [31:0] seed);
    int n;
    for (int i = 0; i < nb; i++) begin
      wvalid = 1'b1;
      wdata  = beat_data(seed, i);
      wstrb  = strbs[i*16 +: 16];
      wlast  = (i == last_idx);
      n = 0;
      while (wready !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      total++;
      if (wready !== 1'b1) begin
        bad++;
        $display("FAIL w_timeout: beat %0d wready=%b required 1", i, wready);
      end
      @(negedge clk);
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic wait_b(output logic [3:0] id, output logic [1:0] resp);
    int n;
    n = 0;
    while (bvalid !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (bvalid !== 1'b1) begin
      bad++;
      $display("FAIL b_timeout: bvalid=%b required 1", bvalid);
    end
    id = bid;
    resp = bresp;
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if (awready !== 1'b0 || wready !== 1'b0 || bvalid !== 1'b0 || bid !== 4'h0 || bresp !== 2'b00 ||
        o_mem_we !== 1'b0 || o_mem_addr !== '0 || o_mem_wdata !== '0 || o_mem_wstrb !== '0 ||
        o_state !== 2'b00) begin
      bad++;
      $display("FAIL reset_values: awready=%b wready=%b bvalid=%b bid=%h bresp=%b we=%b addr=%h state=%b required all 0",
               awready, wready, bvalid, bid, bresp, o_mem_we, o_mem_addr, o_state);
    end
    rst_n = 1'b1;
    wvalid = 1'b1;
    @(negedge clk);
    total++;
    if (awready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release: awready=%b required 1", awready);
    end
    @(negedge clk);
    total++;
    if (wready !== 1'b0 || o_mem_we !== 1'b0) begin
      bad++;
      $display("FAIL idle_w_ignored: wready=%b we=%b required 0 0", wready, o_mem_we);
    end
    wvalid = 1'b0;
  endtask

  task automatic test_incr();
    logic [3:0] id;
    logic [1:0] resp;
    clear_q();
    send_aw(4'd5, 32'h1000_0040, 4'd3, 3'd4, 2'b01);
    total++;
    if (wready !== 1'b1) begin
      bad++;
      $display("FAIL aw_to_wready: wready=%b required 1", wready);
    end
    send_beats(4, {4{16'hFFFF}}, 3, 32'h1111_0000);
    total++;
    if (bvalid !== 1'b1) begin
      bad++;
      $display("FAIL last_to_bvalid: bvalid=%b required 1", bvalid);
    end
    wait_b(id, resp);
    repeat (2) @(negedge clk);
    total++;
    if (id !== 4'd5 || resp !== 2'b00) begin
      bad++;
      $display("FAIL incr_b: bid=%h bresp=%b required 5 00", id, resp);
    end
    total++;
    if (q_addr.size() != 4) begin
      bad++;
      $display("FAIL incr_count: writes=%0d required 4", q_addr.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (q_addr[i] !== 12'(4 + i) || q_data[i] !== beat_data(32'h1111_0000, i) || q_strb[i] !== 16'hFFFF) begin
          bad++;
          $display("FAIL incr_write%0d: addr=%h strb=%h required addr=%h strb=ffff", i, q_addr[i], q_strb[i], 12'(4 + i));
        end
      end
    end
  endtask

  task automatic test_wrap();
    logic [3:0] id;
    logic [1:0] resp;
    clear_q();
    send_aw(4'd2, 32'h1000_FFF0, 4'd1, 3'd4, 2'b01);
    send_beats(2, {4{16'hFFFF}}, 1, 32'h2222_0000);
    wait_b(id, resp);
    total++;
    if (q_addr.size() != 2 || q_addr[0] !== 12'hFFF || q_addr[1] !== 12'h000 || resp !== 2'b00) begin
      bad++;
      $display("FAIL wrap: writes=%0d first=%h second=%h bresp=%b required 2 fff 000 00",
               q_addr.size(), q_addr.size() > 0 ? q_addr[0] : 12'hxxx, q_addr.size() > 1 ? q_addr[1] : 12'hxxx, resp);
    end
  endtask

  task automatic test_decerr();
    logic [3:0] id;
    logic [1:0] resp;
    clear_q();
    send_aw(4'd7, 32'h2000_0000, 4'd2, 3'd4, 2'b01);
    send_beats(3, {4{16'hFFFF}}, 2, 32'h3333_0000);
    wait_b(id, resp);
    total++;
    if (q_addr.size() != 0 || resp !== 2'b11 || id !== 4'd7) begin
      bad++;
      $display("FAIL decerr: writes=%0d bresp=%b bid=%h required 0 11 7", q_addr.size(), resp, id);
    end
  endtask

  task automatic test_slverr();
    logic [3:0] id;
    logic [1:0] resp;
    clear_q();
    send_aw(4'd1, 32'h1000_0000, 4'd0, 3'd3, 2'b01);
    send_beats(1, {4{16'hFFFF}}, 0, 32'h4444_0000);
    wait_b(id, resp);
    total++;
    if (q_addr.size() != 0 || resp !== 2'b10) begin
      bad++;
      $display("FAIL slverr_size: writes=%0d bresp=%b required 0 10", q_addr.size(), resp);
    end
    clear_q();
    send_aw(4'd4, 32'h1000_0300, 4'd3, 3'd4, 2'b01);
    send_beats(4, {4{16'hFFFF}}, 1, 32'h5555_0000);
    wait_b(id, resp);
    total++;
    if (q_addr.size() != 4 || q_addr[3] !== 12'h033 || resp !== 2'b10) begin
      bad++;
      $display("FAIL wlast_early: writes=%0d bresp=%b required 4 10", q_addr.size(), resp);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] id0;
    logic [1:0] resp0;
    int bad_cycles;
    send_aw(4'd9, 32'h1000_0080, 4'd0, 3'd4, 2'b01);
    send_beats(1, {4{16'hFFFF}}, 0, 32'h6666_0000);
    id0 = bid;
    resp0 = bresp;
    total++;
    if (bvalid !== 1'b1 || id0 !== 4'd9 || resp0 !== 2'b00) begin
      bad++;
      $display("FAIL bp_initial: bvalid=%b bid=%h bresp=%b required 1 9 00", bvalid, id0, resp0);
    end
    bad_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bvalid !== 1'b1 || bid !== 4'd9 || bresp !== 2'b00 || awready !== 1'b0) bad_cycles++;
    end
    total++;
    if (bad_cycles != 0) begin
      bad++;
      $display("FAIL bp_stable: unstable cycles=%0d required 0", bad_cycles);
    end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    total++;
    if (awready !== 1'b1 || bvalid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: awready=%b bvalid=%b required 1 0", awready, bvalid);
    end
  endtask

  task automatic test_fixed();
    logic [3:0] id;
    logic [1:0] resp;
    logic [63:0] strbs;
    clear_q();
    strbs = {16'h0000, 16'h0FF0, 16'hF000, 16'h000F};
    send_aw(4'd6, 32'h1000_0100, 4'd2, 3'd4, 2'b00);
    send_beats(3, strbs, 2, 32'h7777_0000);
    wait_b(id, resp);
    total++;
    if (q_addr.size() != 3 || resp !== 2'b00) begin
      bad++;
      $display("FAIL fixed_count: writes=%0d bresp=%b required 3 00", q_addr.size(), resp);
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (q_addr[i] !== 12'h010 || q_strb[i] !== strbs[i*16 +: 16] || q_data[i] !== beat_data(32'h7777_0000, i)) begin
          bad++;
          $display("FAIL fixed_write%0d: addr=%h strb=%h required 010 %h", i, q_addr[i], q_strb[i], strbs[i*16 +: 16]);
        end
      end
    end
  endtask

  task automatic test_perf();
`ifdef SMC_WR_PERF_CNT_EN
    total++;
    if (o_burst_cnt !== 16'd7 || o_err_cnt !== 16'd3) begin
      bad++;
      $display("FAIL perf_cnt: bursts=%0d errs=%0d required 7 3", o_burst_cnt, o_err_cnt);
    end
`endif
  endtask

  task automatic test_reset_mid();
    int bad_cycles;
    clear_q();
    send_aw(4'd3, 32'h1000_0200, 4'd3, 3'd4, 2'b01);
    for (int i = 0; i < 2; i++) begin
      wvalid = 1'b1;
      wdata  = beat_data(32'h8888_0000, i);
      wstrb  = 16'hFFFF;
      wlast  = 1'b0;
      @(negedge clk);
    end
    wdata = beat_data(32'h8888_0000, 2);
    rst_n = 1'b0;
    @(negedge clk);
    total++;
    if (o_state !== 2'b00 || bvalid !== 1'b0 || o_mem_we !== 1'b0 || awready !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: state=%b bvalid=%b we=%b awready=%b required 00 0 0 0", o_state, bvalid, o_mem_we, awready);
    end
    wvalid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (awready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid_release: awready=%b required 1", awready);
    end
    bad_cycles = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bvalid !== 1'b0 || o_mem_we !== 1'b0) bad_cycles++;
    end
    total++;
    if (bad_cycles != 0 || q_addr.size() != 2) begin
      bad++;
      $display("FAIL reset_mid_quiet: bad cycles=%0d writes=%0d required 0 2", bad_cycles, q_addr.size());
    end
  endtask

  initial begin
    test_reset();
    test_incr();
    test_wrap();
    test_decerr();
    test_slverr();
    test_backpressure();
    test_fixed();
    test_perf();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
